hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It drives the 2-bit select of the execute-stage operand muxes (the three-input forwarding muxes) and the 1-bit decode-stage branch-compare forwarding selects. It detects load-use and branch data hazards and stalls/flushes the pipeline for them. It also sequences the multi-cycle multiply/divide unit with a busy counter and keeps a saturating stall-cycle counter.

---
 rtl/hazard_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load-use/branch/mult-div stall detection,
// mult/div busy sequencing and a saturating stall-cycle counter for the
// five-stage MIPS pipeline.
module hazard_unit #(
  parameter int REG_BITS      = 5,
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_BITS      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_BITS-1:0] rs_d,
  input  logic [REG_BITS-1:0] rt_d,
  input  logic [REG_BITS-1:0] rs_e,
  input  logic [REG_BITS-1:0] rt_e,
  input  logic [REG_BITS-1:0] write_reg_e,
  input  logic [REG_BITS-1:0] write_reg_m,
  input  logic [REG_BITS-1:0] write_reg_w,
  input  logic                reg_write_e,
  input  logic                reg_write_m,
  input  logic                reg_write_w,
  input  logic                mem_to_reg_e,
  input  logic                mem_to_reg_m,
  input  logic                branch_d,
  input  logic                muldiv_start_e,
  input  logic                muldiv_use_d,
  output logic [1:0]          fwd_a_e,
  output logic [1:0]          fwd_b_e,
  output logic                fwd_a_d,
  output logic                fwd_b_d,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_e,
  output logic                muldiv_busy,
  output logic                muldiv_done,
  output logic [CNT_BITS-1:0] stall_count
);

  // MULDIV_CYCLES-1 always fits in clog2(MULDIV_CYCLES) bits for MULDIV_CYCLES >= 2.
  localparam int MD_CNT_BITS = $clog2(MULDIV_CYCLES);
  localparam logic [MD_CNT_BITS-1:0] MD_LOAD = MD_CNT_BITS'(MULDIV_CYCLES - 1);
  localparam logic [MD_CNT_BITS-1:0] MD_ONE  = MD_CNT_BITS'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  md_state_e                state_q, state_d;
  logic [MD_CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic [CNT_BITS-1:0]      stall_count_q, stall_count_d;
  logic                     lw_stall, br_stall, md_stall, stall;
  logic                     m_writes, w_writes, e_writes, m_loads;

  // Qualified "this stage produces a real register value" flags; $0 never counts.
  always_comb begin
    m_writes = reg_write_m && (write_reg_m != '0);
    w_writes = reg_write_w && (write_reg_w != '0);
    e_writes = reg_write_e && (write_reg_e != '0);
    m_loads  = mem_to_reg_m && (write_reg_m != '0);
  end

  // Operand forwarding: memory stage is the youngest result, so it wins over writeback.
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (m_writes && (write_reg_m == rs_e))      fwd_a_e = 2'b10;
    else if (w_writes && (write_reg_w == rs_e)) fwd_a_e = 2'b01;
    if (m_writes && (write_reg_m == rt_e))      fwd_b_e = 2'b10;
    else if (w_writes && (write_reg_w == rt_e)) fwd_b_e = 2'b01;
    fwd_a_d = m_writes && (write_reg_m == rs_d);
    fwd_b_d = m_writes && (write_reg_m == rt_d);
  end

  // Hazard detection: any stall source freezes fetch/decode and bubbles execute.
  always_comb begin
    lw_stall = mem_to_reg_e && (write_reg_e != '0) &&
               ((write_reg_e == rs_d) || (write_reg_e == rt_d));
    br_stall = branch_d &&
               ((e_writes && ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                (m_loads  && ((write_reg_m == rs_d) || (write_reg_m == rt_d))));
    md_stall = (state_q == BUSY) && muldiv_use_d;
    stall    = lw_stall || br_stall || md_stall;
  end

  assign stall_f     = stall;
  assign stall_d     = stall;
  assign flush_e     = stall;
  assign muldiv_busy = (state_q == BUSY);
  assign muldiv_done = done_q;
  assign stall_count = stall_count_q;

  // Mult/div sequencer next state: a start while busy is deliberately ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (muldiv_start_e) begin
          state_d = BUSY;
          cnt_d   = MD_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == MD_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - MD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stall counter next value: count stalled cycles, stick at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_BITS'(1);
  end

  // Mult/div state register; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios for hazard_unit with MULDIV_CYCLES=4, CNT_BITS=4.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, muldiv_start_e, muldiv_use_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e, muldiv_busy, muldiv_done;
  logic [3:0] stall_count;

  int errors = 0;
  int checks = 0;

  hazard_unit #(.REG_BITS(5), .MULDIV_CYCLES(4), .CNT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .muldiv_start_e(muldiv_start_e), .muldiv_use_d(muldiv_use_d),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done), .stall_count(stall_count)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    write_reg_e = '0; write_reg_m = '0; write_reg_w = '0;
    reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    mem_to_reg_e = 1'b0; mem_to_reg_m = 1'b0;
    branch_d = 1'b0; muldiv_start_e = 1'b0; muldiv_use_d = 1'b0;
  endtask

  // Two reset edges, released at a falling edge with all inputs idle.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if ({muldiv_busy, muldiv_done} !== 2'b00) begin errors++; $display("[TB] FAIL reset_md: got busy/done=%b expected 00", {muldiv_busy, muldiv_done}); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", stall_count); end
    checks++; if ({fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e} !== 9'b0) begin errors++; $display("[TB] FAIL reset_comb: got %b expected 000000000", {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e}); end
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd3; rt_d = 5'd3;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (stall_count !== 4'd2) begin errors++; $display("[TB] FAIL pre_reset_count: got %0d expected 2", stall_count); end
    do_reset();
    #1;
    checks++; if (stall_count !== 4'd0) begin errors++; $display("[TB] FAIL rereset_count: got %0d expected 0", stall_count); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    rs_e = 5'd3; reg_write_m = 1'b1; write_reg_m = 5'd3; #1;
    checks++; if (fwd_a_e !== 2'b10) begin errors++; $display("[TB] FAIL fwd_m_only: got %b expected 10", fwd_a_e); end
    reg_write_m = 1'b0; reg_write_w = 1'b1; write_reg_w = 5'd3; #1;
    checks++; if (fwd_a_e !== 2'b01) begin errors++; $display("[TB] FAIL fwd_w_only: got %b expected 01", fwd_a_e); end
    reg_write_m = 1'b1; #1;
    checks++; if (fwd_a_e !== 2'b10) begin errors++; $display("[TB] FAIL fwd_m_over_w: got %b expected 10", fwd_a_e); end
    rs_e = 5'd0; write_reg_m = 5'd0; write_reg_w = 5'd0; #1;
    checks++; if (fwd_a_e !== 2'b00) begin errors++; $display("[TB] FAIL fwd_reg0: got %b expected 00", fwd_a_e); end
    rs_e = 5'd9; write_reg_m = 5'd9; rt_e = 5'd4; write_reg_w = 5'd4; #1;
    checks++; if ({fwd_a_e, fwd_b_e} !== 4'b1001) begin errors++; $display("[TB] FAIL fwd_a_m_b_w: got %b expected 1001", {fwd_a_e, fwd_b_e}); end
    reg_write_m = 1'b0; #1;
    checks++; if (fwd_a_e !== 2'b00) begin errors++; $display("[TB] FAIL fwd_no_regwrite: got %b expected 00", fwd_a_e); end
    clear_inputs();
    rs_d = 5'd6; rt_d = 5'd2; reg_write_m = 1'b1; write_reg_m = 5'd6; #1;
    checks++; if ({fwd_a_d, fwd_b_d} !== 2'b10) begin errors++; $display("[TB] FAIL fwd_d_rs: got %b expected 10", {fwd_a_d, fwd_b_d}); end
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("[TB] FAIL fwd_no_stall: got %b expected 000", {stall_f, stall_d, flush_e}); end
    rt_d = 5'd6; #1;
    checks++; if ({fwd_a_d, fwd_b_d} !== 2'b11) begin errors++; $display("[TB] FAIL fwd_d_both: got %b expected 11", {fwd_a_d, fwd_b_d}); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd5; rs_d = 5'd2; rt_d = 5'd5; #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin errors++; $display("[TB] FAIL lu_stall: got %b expected 111", {stall_f, stall_d, flush_e}); end
    @(negedge clk);
    mem_to_reg_e = 1'b0; reg_write_e = 1'b0; write_reg_e = 5'd0;
    mem_to_reg_m = 1'b1; reg_write_m = 1'b1; write_reg_m = 5'd5;
    rs_e = 5'd2; rt_e = 5'd5; rs_d = 5'd0; rt_d = 5'd0; #1;
    checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0010) begin errors++; $display("[TB] FAIL lu_fwd: got %b expected 0010", {fwd_a_e, fwd_b_e}); end
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("[TB] FAIL lu_release: got %b expected 000", {stall_f, stall_d, flush_e}); end
    @(negedge clk); #1;
    checks++; if (stall_count !== 4'd1) begin errors++; $display("[TB] FAIL lu_count: got %0d expected 1", stall_count); end
    clear_inputs();
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd0; #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("[TB] FAIL lu_reg0: got %b expected 000", {stall_f, stall_d, flush_e}); end
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    branch_d = 1'b1; rs_d = 5'd7; rt_d = 5'd1; reg_write_e = 1'b1; write_reg_e = 5'd7; #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin errors++; $display("[TB] FAIL br_alu_stall: got %b expected 111", {stall_f, stall_d, flush_e}); end
    @(negedge clk);
    reg_write_e = 1'b0; write_reg_e = 5'd0; reg_write_m = 1'b1; write_reg_m = 5'd7; #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("[TB] FAIL br_alu_release: got %b expected 000", {stall_f, stall_d, flush_e}); end
    checks++; if ({fwd_a_d, fwd_b_d} !== 2'b10) begin errors++; $display("[TB] FAIL br_alu_fwd: got %b expected 10", {fwd_a_d, fwd_b_d}); end
    @(negedge clk);
    reg_write_m = 1'b0; write_reg_m = 5'd0; rs_d = 5'd1; rt_d = 5'd8;
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd8; #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin errors++; $display("[TB] FAIL br_lw_stall1: got %b expected 111", {stall_f, stall_d, flush_e}); end
    @(negedge clk);
    mem_to_reg_e = 1'b0; reg_write_e = 1'b0; write_reg_e = 5'd0;
    mem_to_reg_m = 1'b1; reg_write_m = 1'b1; write_reg_m = 5'd8; #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin errors++; $display("[TB] FAIL br_lw_stall2: got %b expected 111", {stall_f, stall_d, flush_e}); end
    @(negedge clk);
    mem_to_reg_m = 1'b0; reg_write_m = 1'b0; write_reg_m = 5'd0;
    reg_write_w = 1'b1; write_reg_w = 5'd8; #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("[TB] FAIL br_lw_release: got %b expected 000", {stall_f, stall_d, flush_e}); end
    checks++; if (stall_count !== 4'd3) begin errors++; $display("[TB] FAIL br_count: got %0d expected 3", stall_count); end
    clear_inputs();
    branch_d = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd0; #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("[TB] FAIL br_reg0: got %b expected 000", {stall_f, stall_d, flush_e}); end
    branch_d = 1'b0; write_reg_e = 5'd4; rs_d = 5'd4; #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("[TB] FAIL nobr_alu: got %b expected 000", {stall_f, stall_d, flush_e}); end
    clear_inputs();
  endtask

  task automatic test_muldiv();
    logic expBusy, expDone;
    do_reset();
    muldiv_start_e = 1'b1; muldiv_use_d = 1'b1; #1;
    checks++; if ({muldiv_busy, stall_d} !== 2'b00) begin errors++; $display("[TB] FAIL md_start_cycle: got busy/stall=%b expected 00", {muldiv_busy, stall_d}); end
    @(negedge clk);
    muldiv_start_e = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      expBusy = (k <= 3);
      expDone = (k == 4);
      #1;
      checks++; if ({muldiv_busy, muldiv_done, stall_d} !== {expBusy, expDone, expBusy}) begin errors++; $display("[TB] FAIL md_cycle%0d: got busy/done/stall=%b expected %b", k, {muldiv_busy, muldiv_done, stall_d}, {expBusy, expDone, expBusy}); end
      @(negedge clk);
    end
    checks++; if (stall_count !== 4'd3) begin errors++; $display("[TB] FAIL md_count: got %0d expected 3", stall_count); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic expBusy, expDone;
    do_reset();
    muldiv_start_e = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      muldiv_start_e = (k == 4) || (k == 6);
      expBusy = ((k >= 1) && (k <= 3)) || ((k >= 5) && (k <= 7));
      expDone = (k == 4) || (k == 8);
      #1;
      checks++; if ({muldiv_busy, muldiv_done} !== {expBusy, expDone}) begin errors++; $display("[TB] FAIL b2b_cycle%0d: got busy/done=%b expected %b", k, {muldiv_busy, muldiv_done}, {expBusy, expDone}); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_muldiv_reset();
    do_reset();
    muldiv_start_e = 1'b1;
    @(negedge clk);
    muldiv_start_e = 1'b0; #1;
    checks++; if (muldiv_busy !== 1'b1) begin errors++; $display("[TB] FAIL mdr_busy: got %b expected 1", muldiv_busy); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      #1;
      checks++; if ({muldiv_busy, muldiv_done} !== 2'b00) begin errors++; $display("[TB] FAIL mdr_cycle%0d: got busy/done=%b expected 00", k, {muldiv_busy, muldiv_done}); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] expCount;
    do_reset();
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd3; rs_d = 5'd3;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      expCount = (i < 15) ? 4'(i) : 4'd15;
      #1;
      checks++; if (stall_count !== expCount) begin errors++; $display("[TB] FAIL sat_cycle%0d: got %0d expected %0d", i, stall_count, expCount); end
    end
    clear_inputs();
    @(negedge clk);
    #1;
    checks++; if (stall_count !== 4'd15) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 15", stall_count); end
  endtask

  // Scenario sequence and final summary.
  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_muldiv();
    test_back_to_back();
    test_muldiv_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
